// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared bus widths, constants and state type for the memory responder
package mem_pkg;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 16;

    localparam logic [ADDR_W-1:0] MEM_IO_ADDR  = 24'hFFFFF0;
    localparam logic [DATA_W-1:0] MEM_ERR_DATA = 16'hFFFF;
    localparam logic [ADDR_W-1:0] PC_START     = 24'd9216;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_spram.sv
// rtl/mem_spram.sv - single-port synchronous RAM, storage only
module mem_spram
    import mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 14
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     din,
    output logic [DATA_W-1:0]     dout
);

    logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    // Read-first synchronous port; no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= din;
            end
            dout <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - wait-stated word responder with RAM and display register
module mem_responder
    import mem_pkg::*;
#(
    parameter int                DEPTH_LOG2  = 14,
    parameter int                WAIT_STATES = 1,
    parameter logic [ADDR_W-1:0] IO_ADDR     = MEM_IO_ADDR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              data_ready,
    output logic              busy,
    output logic              err,
    output logic [DATA_W-1:0] seg_value
);

    localparam logic [3:0]      WAIT_INIT = 4'(WAIT_STATES);
    localparam logic [ADDR_W:0] RAM_WORDS = {{ADDR_W{1'b0}}, 1'b1} << DEPTH_LOG2;

    mem_state_e        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] seg_q, seg_d;
    logic              ram_rd_q, ram_rd_d;

    logic              ram_hit;
    logic              io_hit;
    logic              ram_en;
    logic              ram_we;
    logic [DATA_W-1:0] ram_dout;

    assign ram_hit = ({1'b0, addr_q} < RAM_WORDS);
    assign io_hit  = (addr_q == IO_ADDR);

    mem_spram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .clk (clk),
        .en  (ram_en),
        .we  (ram_we),
        .addr(addr_q[DEPTH_LOG2-1:0]),
        .din (wdata_q),
        .dout(ram_dout)
    );

    // RAM read data arrives registered in u_ram at the access edge; it is shown
    // directly during RESP and folded into rdata_q on the way back to IDLE.
    assign rdata      = ram_rd_q ? ram_dout : rdata_q;
    assign data_ready = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign err        = err_q;
    assign seg_value  = seg_q;

    // Next-state: capture in IDLE, count wait states, decode and commit on the last ACCESS edge.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        seg_d    = seg_q;
        ram_rd_d = ram_rd_q;
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    cnt_d   = WAIT_INIT;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d  = RESP;
                    err_d    = 1'b0;
                    ram_rd_d = 1'b0;
                    if (ram_hit) begin
                        ram_en   = 1'b1;
                        ram_we   = we_q;
                        ram_rd_d = !we_q;
                    end else if (io_hit) begin
                        if (we_q) begin
                            seg_d = wdata_q;
                        end else begin
                            rdata_d = seg_q;
                        end
                    end else begin
                        err_d = 1'b1;
                        if (!we_q) begin
                            rdata_d = MEM_ERR_DATA;
                        end
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
                if (ram_rd_q) begin
                    rdata_d  = ram_dout;
                    ram_rd_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            seg_q    <= '0;
            ram_rd_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            seg_q    <= seg_d;
            ram_rd_q <= ram_rd_d;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder with zero and three wait states
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0;
    logic        req3 = 1'b0;
    logic        we = 1'b0;
    logic [23:0] addr = '0;
    logic [15:0] wdata = '0;

    logic [15:0] rdata0, seg0, rdata3, seg3;
    logic        dr0, busy0, err0, dr3, busy3, err3;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_LOG2(14), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .req(req0), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata0), .data_ready(dr0), .busy(busy0), .err(err0), .seg_value(seg0)
    );

    mem_responder #(.DEPTH_LOG2(14), .WAIT_STATES(3)) dut3 (
        .clk(clk), .reset(reset), .req(req3), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata3), .data_ready(dr3), .busy(busy3), .err(err3), .seg_value(seg3)
    );

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [15:0] mem_m [int];
    logic [15:0] seg_m [2];
    logic [15:0] rd_m  [2];

    function automatic logic [15:0] get_rdata(input int sel);
        return (sel != 0) ? rdata3 : rdata0;
    endfunction
    function automatic logic get_dr(input int sel);
        return (sel != 0) ? dr3 : dr0;
    endfunction
    function automatic logic get_busy(input int sel);
        return (sel != 0) ? busy3 : busy0;
    endfunction
    function automatic logic get_err(input int sel);
        return (sel != 0) ? err3 : err0;
    endfunction
    function automatic logic [15:0] get_seg(input int sel);
        return (sel != 0) ? seg3 : seg0;
    endfunction

    function automatic exp_t model(input int sel, input logic w, input logic [23:0] a,
                                   input logic [15:0] d);
        exp_t e;
        int   key;
        e.lat = (sel != 0) ? 4 : 1;
        e.err = 1'b0;
        if (a < 24'd16384) begin
            key = sel * (1 << 24) + int'(a);
            if (w) mem_m[key] = d;
            else   rd_m[sel] = mem_m[key];
        end else if (a == 24'hFFFFF0) begin
            if (w) seg_m[sel] = d;
            else   rd_m[sel] = seg_m[sel];
        end else begin
            e.err = 1'b1;
            if (!w) rd_m[sel] = 16'hFFFF;
        end
        e.rdata = rd_m[sel];
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all_zero(input int sel, input string tag);
        check({tag, "_rdata"}, 32'(get_rdata(sel)), 32'h0);
        check({tag, "_dr"},    32'(get_dr(sel)),    32'h0);
        check({tag, "_busy"},  32'(get_busy(sel)),  32'h0);
        check({tag, "_err"},   32'(get_err(sel)),   32'h0);
        check({tag, "_seg"},   32'(get_seg(sel)),   32'h0);
    endtask

    task automatic do_txn(input int sel, input logic w, input logic [23:0] a,
                          input logic [15:0] d, input string tag);
        exp_t e;
        int   lat;
        bit   got;
        @(negedge clk);
        we = w; addr = a; wdata = d;
        if (sel != 0) req3 = 1'b1; else req0 = 1'b1;
        sb.push_back(model(sel, w, a, d));
        @(posedge clk); #1;
        req0 = 1'b0; req3 = 1'b0;
        check({tag, "_busy_hi"}, 32'(get_busy(sel)), 32'h1);
        lat = 0; got = 1'b0;
        while (!got && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (get_dr(sel)) got = 1'b1;
        end
        e = sb.pop_front();
        check({tag, "_got"},   32'(got),            32'h1);
        check({tag, "_lat"},   32'(lat),            32'(e.lat));
        check({tag, "_rdata"}, 32'(get_rdata(sel)), 32'(e.rdata));
        check({tag, "_err"},   32'(get_err(sel)),   32'(e.err));
        @(posedge clk); #1;
        check({tag, "_dr_one"},  32'(get_dr(sel)),   32'h0);
        check({tag, "_busy_lo"}, 32'(get_busy(sel)), 32'h0);
        check({tag, "_rd_hold"}, 32'(get_rdata(sel)), 32'(e.rdata));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [23:0] hl [4];
        exp_t        e;
        int          nreq, nresp, last;

        seg_m[0] = '0; seg_m[1] = '0; rd_m[0] = '0; rd_m[1] = '0;

        #12;
        check_all_zero(0, "rst0");
        check_all_zero(1, "rst3");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_busy", 32'(busy3), 32'h0);
            check("idle_dr",   32'(dr3),   32'h0);
        end

        do_txn(0, 1'b1, 24'd9216, 16'hA5C3, "w0_pre");
        do_txn(0, 1'b0, 24'd9216, 16'h0000, "w0_rd");

        do_txn(1, 1'b1, 24'd100, 16'h1234, "w3_wr100");
        do_txn(1, 1'b0, 24'd100, 16'h0000, "w3_rd100");
        do_txn(1, 1'b1, 24'd0,   16'h0ABC, "w3_wr0");

        do_txn(1, 1'b1, 24'hFFFFF0, 16'hBEEF, "io_wr");
        check("io_seg", 32'(seg3), 32'hBEEF);
        do_txn(1, 1'b0, 24'hFFFFF0, 16'h0000, "io_rd");
        do_txn(1, 1'b0, 24'h800000, 16'h0000, "miss_rd");
        do_txn(1, 1'b1, 24'h800000, 16'h5555, "miss_wr");
        check("miss_seg", 32'(seg3), 32'hBEEF);
        do_txn(1, 1'b0, 24'd0,   16'h0000, "miss_ram0");
        do_txn(1, 1'b0, 24'd100, 16'h0000, "miss_ram100");

        for (int i = 0; i < 4; i++) begin
            do_txn(1, 1'b1, 24'(200 + i), 16'(16'h2000 + i * 16'h0111), "pre_held");
        end
        hl[0] = 24'd203; hl[1] = 24'd201; hl[2] = 24'd200; hl[3] = 24'd202;
        nreq = 0; nresp = 0; last = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (dr3) begin
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("held_rdata", 32'(rdata3), 32'(e.rdata));
                    check("held_err",   32'(err3),   32'(e.err));
                end else begin
                    check("held_extra_resp", 32'(sb.size()), 32'h1);
                end
                if (last >= 0) check("held_spacing", 32'(c - last), 32'd6);
                last = c;
                nresp++;
            end
            if (!busy3) begin
                if (nreq < 4) begin
                    addr = hl[nreq]; we = 1'b0; wdata = 16'h0; req3 = 1'b1;
                    sb.push_back(model(1, 1'b0, hl[nreq], 16'h0));
                    nreq++;
                end else begin
                    req3 = 1'b0;
                end
            end else begin
                addr  = 24'h800000 | 24'($urandom_range(0, 65535));
                we    = 1'($urandom_range(0, 1));
                wdata = 16'($urandom);
            end
        end
        req3 = 1'b0;
        check("held_nresp", 32'(nresp), 32'd4);
        check("held_sb_empty", 32'(sb.size()), 32'd0);

        do_txn(1, 1'b1, 24'd50, 16'h0001, "pre50");
        @(negedge clk);
        we = 1'b1; addr = 24'd50; wdata = 16'h7777; req3 = 1'b1;
        @(posedge clk); #1;
        req3 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_all_zero(1, "midrst");
        seg_m[0] = '0; seg_m[1] = '0; rd_m[0] = '0; rd_m[1] = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("midrst_dr_in", 32'(dr3), 32'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("midrst_dr_after", 32'(dr3),   32'h0);
            check("midrst_busy",     32'(busy3), 32'h0);
        end
        do_txn(1, 1'b0, 24'd50, 16'h0000, "rd50");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the 16-bit core's data/instruction bus. Accepts one word request at a time, 24-bit address, 16-bit data. Serves it from an on-chip single-port RAM after a configurable number of wait states and returns a one-cycle `data_ready` strobe. Also decodes one memory-mapped display register that feeds the seven-segment mux. It replaces the core's current zero-latency memory assumption.

## Interface
- `DEPTH_LOG2`, default 14: RAM holds 2^DEPTH_LOG2 16-bit words, at word addresses 0 .. 2^DEPTH_LOG2-1.
- `WAIT_STATES`, default 1: extra ACCESS cycles per request. Legal range 0..15.
- `IO_ADDR`, default 24'hFFFFF0: word address of the display register.
- `clk`  in  1: clock.
- `reset`  in  1: reset, asynchronous, active-high.
- `req`  in  1: request valid. Sampled only in IDLE.
- `we`  in  1: 1 = write, 0 = read. Latched with `req`.
- `addr`  in  24: word address. Latched with `req`.
- `wdata`  in  16: write data. Latched with `req`.
- `rdata`  out  16: read data. Valid while `data_ready`=1 and held until the next response.
- `data_ready`  out  1: one-cycle completion strobe, for both reads and writes.
- `busy`  out  1: high whenever the state is not IDLE.
- `err`  out  1: out-of-range access. Valid only with `data_ready`.
- `seg_value`  out  16: display register, drives d3..d0 of the seven-segment mux.

## Operation
- States:
  - IDLE: `req`=1 latches `we`, `addr` and `wdata`, loads `cnt`←WAIT_STATES and moves to ACCESS. `req`=0 stays in IDLE.
  - ACCESS: while `cnt`≠0, decrement `cnt`. When `cnt`=0, perform the access, register `rdata` and `err`, and move to RESP.
  - RESP: `data_ready`=1. Moves unconditionally to IDLE.
- Address decode uses the latched address:
  - RAM hit when `addr` < 2^DEPTH_LOG2. Index is `addr[DEPTH_LOG2-1:0]`.
  - IO hit when `addr` == IO_ADDR. A write sets `seg_value`←`wdata`. A read returns `seg_value`.
  - Anything else is a miss. A write is dropped. A read returns 16'hFFFF. `err`=1 in RESP.
- A write returns `rdata` unchanged from its previous value, with `err`=0 on a hit.
- `req` in ACCESS or RESP is ignored. Inputs may change freely while `busy`=1.
- The requester must drop `req` in the `data_ready` cycle. A `req` still high in the following IDLE cycle is a new request.
- Reset value of every output is 0: `rdata`, `data_ready`, `busy`, `err`, `seg_value`. State returns to IDLE. RAM contents are not reset.

## Timing
- Edge E0 samples `req` in IDLE. ACCESS spans edges E1..E(W+1). The access takes effect at E(W+1). `data_ready` is high for the single cycle between E(W+1) and E(W+2).
- Request-to-response latency is W+1 edges. With W=0, `data_ready` rises one edge after capture.
- Maximum throughput is one request per W+3 cycles.
- `busy` rises at E0 and falls at E(W+2).
- Reset asserted mid-ACCESS, before E(W+1): the write is aborted, RAM and `seg_value` are unchanged, and `data_ready` is never asserted.
- Reset at or after E(W+1): the already-committed write stands. Outputs clear asynchronously.
- RAM read is synchronous: data is registered at the access edge, with no combinational path from `addr` to `rdata`.

## Structure
- Shared package `mem_pkg` holds:
  - the state enum (IDLE, ACCESS, RESP),
  - the constants `MEM_IO_ADDR` (24'hFFFFF0), `MEM_ERR_DATA` (16'hFFFF) and `PC_START` (24'd9216),
  - the bus widths (24/16).
- Sub-module `mem_spram`: single-port synchronous RAM.
  - Ports: `clk`, `en`, `we`, `addr[DEPTH_LOG2-1:0]`, `din[15:0]`, `dout[15:0]`.
  - Holds the storage only; no reset. Written so that it infers block RAM.
- The FSM, wait counter, address decode and display register live in `mem_responder`.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle → every output is 0 immediately and the state is IDLE. Release, then hold `req`=0 for 10 cycles → `busy`=0 and `data_ready`=0 throughout.
- Read, W=0: RAM[9216]=16'hA5C3 preloaded; pulse `req`, `we`=0, `addr`=9216 → `data_ready` high exactly one edge later for one cycle, `rdata`=16'hA5C3, `err`=0.
- Write then read, W=3: write 16'h1234 to address 100 → `data_ready` 4 edges after capture. Read address 100 → `rdata`=16'h1234, latency again 4 edges.
- IO and miss: write 16'hBEEF to 24'hFFFFF0 → `seg_value`=16'hBEEF after the response. Read 24'h800000 → `rdata`=16'hFFFF, `err`=1 with `data_ready`. Write 16'h5555 to 24'h800000 → no RAM or `seg_value` change, `err`=1.
- Busy and held `req`: hold `req`=1 continuously with `addr` changing while busy → responses use only the addresses captured in IDLE; one response per W+3 cycles; no response is lost or duplicated.
- Reset mid-write, W=3: start a write of 16'h7777 to address 50, where RAM[50]=16'h0001. Assert `reset` at E2 → no `data_ready`; a later read returns 16'h0001.
